// File: rtl/control_sequencer.sv
// Hardwired Moore control unit. It runs fetch (T0-T3), decodes in T4, then steps the
// ALU or MULDIV execute states. Every control output is registered from next-state.
module control_sequencer #(
    parameter int REG_COUNT = 16,
    parameter int OPC_W     = 5
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 run,
    input  logic [31:0]          ir,
    input  logic                 mem_ready,
    output logic [REG_COUNT-1:0] reg_in,
    output logic [REG_COUNT-1:0] reg_out,
    output logic                 hi_in,
    output logic                 lo_in,
    output logic                 z_in,
    output logic                 pc_in,
    output logic                 mdr_in,
    output logic                 y_in,
    output logic                 mar_in,
    output logic                 ir_in,
    output logic                 hi_out,
    output logic                 lo_out,
    output logic                 zhi_out,
    output logic                 zlo_out,
    output logic                 pc_out,
    output logic                 mdr_out,
    output logic                 inc_pc,
    output logic                 mdr_read,
    output logic                 mem_read,
    output logic [OPC_W-1:0]     alu_code,
    output logic                 busy,
    output logic                 halted,
    output logic                 illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_T8, S_END, S_HALT
    } state_t;

    typedef struct packed {
        logic [REG_COUNT-1:0] reg_in;
        logic [REG_COUNT-1:0] reg_out;
        logic hi_in, lo_in, z_in, pc_in, mdr_in, y_in, mar_in, ir_in;
        logic hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out;
        logic inc_pc, mdr_read, mem_read;
        logic [OPC_W-1:0] alu_code;
        logic busy, halted, illegal;
    } ctl_t;

    localparam logic [OPC_W-1:0] OP_ALU_LO = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_ALU_HI = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_DIV    = OPC_W'(14);
    localparam logic [OPC_W-1:0] OP_MUL    = OPC_W'(15);
    localparam logic [OPC_W-1:0] OP_NOP    = OPC_W'(26);
    localparam logic [OPC_W-1:0] OP_HALT   = OPC_W'(27);
    // END dwells three cycles so every instruction retires cleanly before the next fetch.
    localparam logic [1:0]       END_LAST  = 2'd2;

    state_t           state_q, state_d;
    ctl_t             ctl_q, ctl_d;
    logic [1:0]       end_cnt_q, end_cnt_d;
    logic [OPC_W-1:0] op_q, op_s, ir_op;
    logic [3:0]       ra_q, rb_q, rc_q, ra_s, rb_s, rc_s;

    function automatic logic [REG_COUNT-1:0] onehot(input logic [3:0] f);
        return {{(REG_COUNT-1){1'b0}}, 1'b1} << (32'(f) % REG_COUNT);
    endfunction

    function automatic logic is_alu(input logic [OPC_W-1:0] op);
        return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
    endfunction

    function automatic logic is_md(input logic [OPC_W-1:0] op);
        return (op == OP_DIV) || (op == OP_MUL);
    endfunction

    assign ir_op = ir[31 -: OPC_W];

    // IR is only guaranteed in T4; later execute states use the copy captured there.
    always_comb begin
        if (state_q == S_T4) begin
            op_s = ir_op;
            ra_s = ir[26:23];
            rb_s = ir[22:19];
            rc_s = ir[18:15];
        end else begin
            op_s = op_q;
            ra_s = ra_q;
            rb_s = rb_q;
            rc_s = rc_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        end_cnt_d = '0;
        case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   if (mem_ready) state_d = S_T3;
            S_T3:   state_d = S_T4;
            S_T4: begin
                if (is_alu(op_s) || is_md(op_s)) state_d = S_T5;
                else if (op_s == OP_HALT)        state_d = S_HALT;
                else                             state_d = S_END;
            end
            S_T5:   state_d = S_T6;
            S_T6:   state_d = S_T7;
            S_T7:   state_d = is_md(op_s) ? S_T8 : S_END;
            S_T8:   state_d = S_END;
            S_END: begin
                if (end_cnt_q == END_LAST) state_d = run ? S_T0 : S_IDLE;
                else                       end_cnt_d = end_cnt_q + 2'd1;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ctl_d      = '0;
        ctl_d.busy = (state_d != S_IDLE) && (state_d != S_HALT);
        case (state_d)
            S_T0: begin
                ctl_d.pc_out = 1'b1;
                ctl_d.mar_in = 1'b1;
                ctl_d.inc_pc = 1'b1;
                ctl_d.z_in   = 1'b1;
            end
            S_T1: begin
                ctl_d.zlo_out = 1'b1;
                ctl_d.pc_in   = 1'b1;
            end
            S_T2: begin
                ctl_d.mem_read = 1'b1;
                ctl_d.mdr_read = 1'b1;
                ctl_d.mdr_in   = 1'b1;
            end
            S_T3: begin
                ctl_d.mdr_out = 1'b1;
                ctl_d.ir_in   = 1'b1;
            end
            S_T5: begin
                ctl_d.reg_out = onehot(is_md(op_s) ? ra_s : rb_s);
                ctl_d.y_in    = 1'b1;
            end
            S_T6: begin
                ctl_d.reg_out  = onehot(is_md(op_s) ? rb_s : rc_s);
                ctl_d.z_in     = 1'b1;
                ctl_d.alu_code = op_s;
            end
            S_T7: begin
                ctl_d.zlo_out = 1'b1;
                if (is_md(op_s)) ctl_d.lo_in  = 1'b1;
                else             ctl_d.reg_in = onehot(ra_s);
            end
            S_T8: begin
                ctl_d.zhi_out = 1'b1;
                ctl_d.hi_in   = 1'b1;
            end
            S_HALT: ctl_d.halted = 1'b1;
            default: ;
        endcase
        // Only nop and undefined opcodes go straight from decode to END.
        ctl_d.illegal = (state_q == S_T4) && (state_d == S_END) && (op_s != OP_NOP);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= S_IDLE;
            ctl_q     <= '0;
            end_cnt_q <= '0;
            op_q      <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rc_q      <= '0;
        end else begin
            state_q   <= state_d;
            ctl_q     <= ctl_d;
            end_cnt_q <= end_cnt_d;
            if (state_q == S_T4) begin
                op_q <= op_s;
                ra_q <= ra_s;
                rb_q <= rb_s;
                rc_q <= rc_s;
            end
        end
    end

    assign reg_in   = ctl_q.reg_in;
    assign reg_out  = ctl_q.reg_out;
    assign hi_in    = ctl_q.hi_in;
    assign lo_in    = ctl_q.lo_in;
    assign z_in     = ctl_q.z_in;
    assign pc_in    = ctl_q.pc_in;
    assign mdr_in   = ctl_q.mdr_in;
    assign y_in     = ctl_q.y_in;
    assign mar_in   = ctl_q.mar_in;
    assign ir_in    = ctl_q.ir_in;
    assign hi_out   = ctl_q.hi_out;
    assign lo_out   = ctl_q.lo_out;
    assign zhi_out  = ctl_q.zhi_out;
    assign zlo_out  = ctl_q.zlo_out;
    assign pc_out   = ctl_q.pc_out;
    assign mdr_out  = ctl_q.mdr_out;
    assign inc_pc   = ctl_q.inc_pc;
    assign mdr_read = ctl_q.mdr_read;
    assign mem_read = ctl_q.mem_read;
    assign alu_code = ctl_q.alu_code;
    assign busy     = ctl_q.busy;
    assign halted   = ctl_q.halted;
    assign illegal  = ctl_q.illegal;

endmodule
